multi_digit_counter: RTL and testbench

Parametrised N-digit, radix-R up/down counter; generalises the single-digit advanced counter. Provides configurable digit count and radix, step of 1 or 2, wrap or saturate mode, optional programmable maximum, synchronous parallel load, and registered carry/borrow pulses for cascading. Sits between the input-conditioning logic (debounced `en` pulses) and the display/decoder stage, which consumes `cnt_out` digit by digit.

---
 rtl/multi_digit_counter.sv | 144 ++++++++++++++
 tb/tb_multi_digit_counter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_counter.sv
// N-digit radix-R up/down counter with step 1/2, wrap or saturate, programmable
// limit, parallel load and registered carry/borrow pulses for cascading.

module mdc_digit #(
    parameter int W     = 4,
    parameter int RADIX = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] y,
    output logic         cout
);
    localparam logic [W+1:0] RAD = (W+2)'(RADIX);

    logic [W+1:0] aa, bb, t;

    always_comb begin
        aa = {2'b00, a};
        bb = {2'b00, b} + {{(W+1){1'b0}}, cin};
        if (!sub) begin
            t    = aa + bb;
            cout = (t >= RAD);
            if (cout) t = t - RAD;
        end else begin
            cout = (aa < bb);
            t    = cout ? (aa + RAD - bb) : (aa - bb);
        end
        y = W'(t);
    end
endmodule

module multi_digit_counter #(
    parameter int DIGITS = 4,
    parameter int W      = 4,
    parameter int RADIX  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  step2,
    input  logic                  wrap,
    input  logic                  load,
    input  logic [DIGITS*W-1:0]   load_val,
    input  logic                  max_en,
    input  logic [DIGITS*W-1:0]   max_val,
    output logic [DIGITS*W-1:0]   cnt_out,
    output logic                  carry_out,
    output logic                  borrow_out
);
    typedef logic [DIGITS-1:0][W-1:0] num_t;

    localparam logic [W-1:0] DMAX = W'(RADIX - 1);
    localparam num_t         ONE  = num_t'(1);
    // Radix 2 with one digit cannot represent a step of 2; it always overflows.
    localparam logic         TINY = (RADIX == 2) && (DIGITS == 1);

    num_t cnt, cnt_d, ld_raw, mx_raw, ld_s, mx_s, all_max, lim, stp;
    num_t sum, dif, lm1;
    logic [DIGITS:0] ac, sc, lc;
    logic carry_d, borrow_d, step_ovf;

    assign ld_raw = load_val;
    assign mx_raw = max_val;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_dig
            assign ld_s[i]    = (ld_raw[i] >= DMAX) ? DMAX : ld_raw[i];
            assign mx_s[i]    = (mx_raw[i] >= DMAX) ? DMAX : mx_raw[i];
            assign all_max[i] = DMAX;

            mdc_digit #(.W(W), .RADIX(RADIX)) u_add (
                .a(cnt[i]), .b(stp[i]), .sub(1'b0), .cin(ac[i]), .y(sum[i]), .cout(ac[i+1]));
            mdc_digit #(.W(W), .RADIX(RADIX)) u_sub (
                .a(cnt[i]), .b(stp[i]), .sub(1'b1), .cin(sc[i]), .y(dif[i]), .cout(sc[i+1]));
            mdc_digit #(.W(W), .RADIX(RADIX)) u_lm1 (
                .a(lim[i]), .b(ONE[i]), .sub(1'b1), .cin(lc[i]), .y(lm1[i]), .cout(lc[i+1]));
        end
    endgenerate

    assign ac[0]    = 1'b0;
    assign sc[0]    = 1'b0;
    assign lc[0]    = 1'b0;
    assign lim      = max_en ? mx_s : all_max;
    assign step_ovf = step2 & TINY;

    // Step expressed as radix digits: in radix 2 a step of 2 is "10".
    always_comb begin
        stp = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == 0)
                stp[k] = !step2 ? W'(1) : ((RADIX > 2) ? W'(2) : '0);
            else if (k == 1)
                stp[k] = W'(step2 && (RADIX == 2));
        end
    end

    // Wrap results use V <= L, so the overshoot past L is at most 2.
    always_comb begin
        cnt_d    = cnt;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            cnt_d = ld_s;
        end else if (max_en && (cnt > lim)) begin
            cnt_d = lim;
        end else if (en && up) begin
            if (!(ac[DIGITS] | step_ovf) && !(sum > lim)) begin
                cnt_d = sum;
            end else if (wrap) begin
                cnt_d   = (step2 && (cnt == lim) && (lim != '0)) ? ONE : '0;
                carry_d = 1'b1;
            end else begin
                cnt_d = lim;
            end
        end else if (en) begin
            if (!(sc[DIGITS] | step_ovf)) begin
                cnt_d = dif;
            end else if (wrap) begin
                cnt_d    = (!step2 || (cnt == ONE) || (lim == '0)) ? lim : lm1;
                borrow_d = 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            cnt        <= cnt_d;
            carry_out  <= carry_d;
            borrow_out <= borrow_d;
        end
    end

    assign cnt_out = cnt;
endmodule

// File: tb/tb_multi_digit_counter.sv
// Scoreboard bench: integer reference model feeds an expected queue that a
// monitor drains once per clock, independent of the stimulus process.

module tb_multi_digit_counter;
    localparam int DIGITS = 4;
    localparam int W      = 4;
    localparam int RADIX  = 10;
    localparam int DW     = DIGITS * W;
    localparam int MAXV   = RADIX ** DIGITS - 1;

    typedef struct {
        logic [DW-1:0] cnt;
        logic          c;
        logic          b;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0, up = 1'b0, step2 = 1'b0, wrap = 1'b0, load = 1'b0, max_en = 1'b0;
    logic [DW-1:0] load_val = '0, max_val = '0;
    logic [DW-1:0] cnt_out;
    logic          carry_out, borrow_out;

    exp_t q[$];
    int   v = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    multi_digit_counter #(.DIGITS(DIGITS), .W(W), .RADIX(RADIX)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .step2(step2), .wrap(wrap),
        .load(load), .load_val(load_val), .max_en(max_en), .max_val(max_val),
        .cnt_out(cnt_out), .carry_out(carry_out), .borrow_out(borrow_out));

    always #5 clk = ~clk;

    function automatic int san(input logic [DW-1:0] x);
        int r = 0, p = 1, d;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(x[i*W +: W]);
            if (d >= RADIX) d = RADIX - 1;
            r += d * p;
            p *= RADIX;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] enc(input int x);
        logic [DW-1:0] o = '0;
        for (int i = 0; i < DIGITS; i++) begin
            o[i*W +: W] = W'(x % RADIX);
            x = x / RADIX;
        end
        return o;
    endfunction

    // Apply one cycle of inputs at a falling edge and queue the expected result.
    task automatic drive(input logic e_, u_, s2_, w_, ld_, input logic [DW-1:0] lv_,
                         input logic me_, input logic [DW-1:0] mv_);
        int   lim, m, s;
        logic c, b;
        en = e_; up = u_; step2 = s2_; wrap = w_; load = ld_;
        load_val = lv_; max_en = me_; max_val = mv_;
        lim = me_ ? san(mv_) : MAXV;
        m   = lim + 1;
        s   = s2_ ? 2 : 1;
        c   = 1'b0;
        b   = 1'b0;
        if (ld_) v = san(lv_);
        else if (me_ && v > lim) v = lim;
        else if (e_ && u_) begin
            if (v + s <= lim) v = v + s;
            else if (w_) begin v = (v + s) % m; c = 1'b1; end
            else v = lim;
        end else if (e_) begin
            if (v >= s) v = v - s;
            else if (w_) begin v = ((v - s) % m + m) % m; b = 1'b1; end
            else v = 0;
        end
        q.push_back('{enc(v), c, b});
        @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (cnt_out !== '0 || carry_out !== 1'b0 || borrow_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got cnt=%h c=%b b=%b, want cnt=0 c=0 b=0",
                     name, cnt_out, carry_out, borrow_out);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (cnt_out !== e.cnt || carry_out !== e.c || borrow_out !== e.b) begin
                    n_bad++;
                    $display("FAIL vec %0d: got cnt=%h c=%b b=%b, want cnt=%h c=%b b=%b",
                             n_vec, cnt_out, carry_out, borrow_out, e.cnt, e.c, e.b);
                end
            end
        end
    end

    initial begin : stim
        logic [DW-1:0] z, mv, lv, tmp;
        logic          me;
        int            k;
        z = '0;
        #2 check_zero("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Up wrap 9998 -> 9999 -> 0000 (carry) -> 0001
        drive(0, 0, 0, 0, 1, enc(9998), 0, z);
        repeat (3) drive(1, 1, 0, 1, 0, z, 0, z);
        // Digit ripple
        drive(0, 0, 0, 0, 1, enc(199), 0, z);
        drive(1, 1, 1, 1, 0, z, 0, z);
        drive(0, 0, 0, 0, 1, enc(200), 0, z);
        drive(1, 0, 0, 1, 0, z, 0, z);
        drive(0, 0, 0, 0, 1, enc(1), 0, z);
        drive(1, 0, 1, 1, 0, z, 0, z);
        // Saturate up and down
        drive(0, 0, 0, 0, 1, enc(9997), 0, z);
        repeat (2) drive(1, 1, 1, 0, 0, z, 0, z);
        drive(0, 0, 0, 0, 1, enc(1), 0, z);
        repeat (2) drive(1, 0, 1, 0, 0, z, 0, z);
        // Programmable limit 25, then over-limit load is clamped
        drive(0, 0, 0, 0, 1, enc(24), 1, enc(25));
        drive(1, 1, 1, 1, 0, z, 1, enc(25));
        drive(0, 0, 0, 0, 1, enc(40), 1, enc(25));
        drive(1, 1, 0, 1, 0, z, 1, enc(25));
        drive(1, 1, 0, 1, 0, z, 1, enc(25));
        // Sanitising and load priority over en
        drive(0, 0, 0, 0, 1, 16'h00C3, 0, z);
        drive(1, 1, 0, 1, 1, enc(5), 0, z);
        drive(0, 0, 0, 0, 1, enc(9), 1, 16'h00F2);
        drive(1, 1, 1, 1, 0, z, 1, 16'h00F2);
        // Limit of zero: every step pulses and V stays 0
        drive(1, 1, 0, 1, 0, z, 1, z);
        drive(1, 1, 1, 1, 0, z, 1, z);
        drive(1, 0, 0, 1, 0, z, 1, z);
        drive(1, 0, 1, 1, 0, z, 1, z);
        // Limit of one, down by 2 from 0
        drive(1, 0, 1, 1, 0, z, 1, enc(1));

        // Async reset between edges while counting
        drive(0, 0, 0, 0, 1, enc(5000), 0, z);
        drive(1, 1, 0, 1, 0, z, 0, z);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        v = 0;
        rst_n = 1'b1;
        drive(1, 1, 0, 1, 0, z, 0, z);

        me = 1'b0;
        mv = enc(25);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) me = ~me;
            if ($urandom_range(0, 29) == 0) begin
                k   = $urandom_range(0, DIGITS);
                tmp = DW'($urandom);
                mv  = tmp & ((DW'(1) << (k * W)) - DW'(1));
            end
            lv = DW'($urandom);
            drive($urandom_range(0, 9) < 8, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 99) < 4, lv, me, mv);
        end

        @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected results left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
